// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator / interval meter family:
// measurement FSM states and the default counter width.
package pulse_pkg;

    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } meas_state_e;

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector for the measured pulse train. Defining
// PULSE_INTERVAL_METER_SYNC_EN inserts a two-flop synchronizer in front of it.
module pulse_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic rise
);

    logic sampled;
    logic prev_q;
    logic prev_d;

`ifdef PULSE_INTERVAL_METER_SYNC_EN
    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;

    always_comb begin
        sync1_d = pulse_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sampled = sync2_q;
`else
    assign sampled = pulse_in;
`endif

    always_comb begin
        prev_d = sampled;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // A held-high input produces exactly one rise: prev_q follows it next cycle.
    assign rise = sampled & ~prev_q;

endmodule

// File: rtl/pulse_interval_meter.sv
// Measures clk cycles between consecutive rising edges of pulse_in and
// presents each interval on a valid/ready result port. Optional input
// synchronizer: PULSE_INTERVAL_METER_SYNC_EN.
module pulse_interval_meter
    import pulse_pkg::*;
#(
    parameter int          CNT_W       = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] meas_time,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             meas_sat,
    output logic             timeout,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    // A limit the saturating counter can never reach is treated as disabled.
    localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0) &&
        ((CNT_W >= 32) ? 1'b1 : (64'(TIMEOUT_CYC) < (64'd1 << CNT_W)));

    logic             rise;
    logic             new_result;

    meas_state_e      state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             sat_q,        sat_d;
    logic [CNT_W-1:0] meas_time_q,  meas_time_d;
    logic             meas_sat_q,   meas_sat_d;
    logic             meas_valid_q, meas_valid_d;
    logic             timeout_q,    timeout_d;
    logic             overrun_q,    overrun_d;

    pulse_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .rise     (rise)
    );

    // Result handshake: a result transfers on a rising clk edge where
    // meas_valid && meas_ready. While meas_valid is high and unaccepted,
    // meas_time/meas_sat are frozen; a result produced in that time is dropped
    // (overrun). A result produced in the transfer cycle replaces the old one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        meas_time_d  = meas_time_q;
        meas_sat_d   = meas_sat_q;
        meas_valid_d = meas_valid_q;
        timeout_d    = 1'b0;
        overrun_d    = overrun_q;
        new_result   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(1);
                    sat_d   = 1'b0;
                end
            end
            COUNT: begin
                // cnt_q equals cycles elapsed since the opening edge.
                if (rise) begin
                    new_result = 1'b1;
                    cnt_d      = CNT_W'(1);
                    sat_d      = 1'b0;
                end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_VAL)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    sat_d     = 1'b0;
                    timeout_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end
        endcase

        if (new_result) begin
            if (meas_valid_q && !meas_ready) begin
                overrun_d = 1'b1;
            end else begin
                meas_time_d  = cnt_q;
                meas_sat_d   = sat_q;
                meas_valid_d = 1'b1;
            end
        end else if (meas_valid_q && meas_ready) begin
            meas_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            meas_time_q  <= '0;
            meas_sat_q   <= 1'b0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            meas_time_q  <= meas_time_d;
            meas_sat_q   <= meas_sat_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    assign meas_time  = meas_time_q;
    assign meas_valid = meas_valid_q;
    assign meas_sat   = meas_sat_q;
    assign timeout    = timeout_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Bench for pulse_interval_meter: two instances (wide counter with a 50-cycle
// timeout, 4-bit counter without timeout) share one stimulus stream.
module tb_pulse_interval_meter;

    localparam int A_W  = 32;
    localparam int A_TO = 50;
    localparam int B_W  = 4;
    localparam int B_TO = 0;
`ifdef PULSE_INTERVAL_METER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    // ---------------- clock / reset / DUTs ----------------
    logic           clk = 1'b0;
    logic           rst;
    logic           pulse_in;
    logic           meas_ready;

    logic [A_W-1:0] a_time;
    logic           a_valid, a_sat, a_timeout, a_overrun;
    logic [B_W-1:0] b_time;
    logic           b_valid, b_sat, b_timeout, b_overrun;

    always #5 clk = ~clk;

    pulse_interval_meter #(.CNT_W(A_W), .TIMEOUT_CYC(A_TO)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (pulse_in),
        .meas_time  (a_time),
        .meas_valid (a_valid),
        .meas_ready (meas_ready),
        .meas_sat   (a_sat),
        .timeout    (a_timeout),
        .overrun    (a_overrun)
    );

    pulse_interval_meter #(.CNT_W(B_W), .TIMEOUT_CYC(B_TO)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (pulse_in),
        .meas_time  (b_time),
        .meas_valid (b_valid),
        .meas_ready (meas_ready),
        .meas_sat   (b_sat),
        .timeout    (b_timeout),
        .overrun    (b_overrun)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q0[$];   // {sat, time} expected from dut_a
    logic [32:0] exp_q1[$];   // {sat, time} expected from dut_b

    // Reference model: works on edge timestamps, not on counters.
    longint cyc = 0;
    bit     m_in_rst = 1'b1;
    bit     prev_p = 1'b0;
    bit     dly[2];
    bit     m_started[2];
    longint m_start[2];
    bit     m_pending[2];
    bit     m_ovr[2];
    bit     m_to_s[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit rise, input bit rdy,
                              output bit push, output logic [32:0] val);
        longint maxv;
        longint iv;
        longint lim;
        maxv = (i == 0) ? ((64'd1 << A_W) - 1) : ((64'd1 << B_W) - 1);
        lim  = (i == 0) ? A_TO : B_TO;
        push = 1'b0;
        val  = '0;
        m_to_s[i] = 1'b0;
        if (rise) begin
            if (m_started[i]) begin
                iv = cyc - m_start[i];
                if (iv > maxv) val = {1'b1, 32'(maxv)};
                else           val = {1'b0, 32'(iv)};
                if (m_pending[i] && !rdy) begin
                    m_ovr[i] = 1'b1;
                end else begin
                    push = 1'b1;
                    m_pending[i] = 1'b1;
                end
            end else if (m_pending[i] && rdy) begin
                m_pending[i] = 1'b0;
            end
            m_started[i] = 1'b1;
            m_start[i]   = cyc;
        end else begin
            if (m_started[i] && lim != 0 && (cyc - m_start[i]) == lim) begin
                m_to_s[i]    = 1'b1;
                m_started[i] = 1'b0;
            end
            if (m_pending[i] && rdy) m_pending[i] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        bit          p;
        bit          rise;
        bit          push;
        logic [32:0] val;
        cyc++;
        if (!rst) begin
            m_in_rst = 1'b1;
            prev_p   = 1'b0;
            dly[0]   = 1'b0;
            dly[1]   = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_started[i] = 1'b0;
                m_pending[i] = 1'b0;
                m_ovr[i]     = 1'b0;
                m_to_s[i]    = 1'b0;
            end
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            m_in_rst = 1'b0;
            p = (SYNC_LAT == 0) ? pulse_in : dly[1];
            dly[1] = dly[0];
            dly[0] = pulse_in;
            rise   = p && !prev_p;
            prev_p = p;
            for (int i = 0; i < 2; i++) begin
                model_step(i, rise, meas_ready, push, val);
                if (push) begin
                    if (i == 0) exp_q0.push_back(val);
                    else        exp_q1.push_back(val);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic check_inst(input int i, input logic v, input logic [31:0] t, input logic s,
                              input logic to, input logic ov);
        string       tag;
        logic [32:0] head;
        int          qsz;
        tag = (i == 0) ? "a" : "b";
        chk({tag, ".meas_valid"}, 64'(v),  64'(m_pending[i]));
        chk({tag, ".timeout"},    64'(to), 64'(m_to_s[i]));
        chk({tag, ".overrun"},    64'(ov), 64'(m_ovr[i]));
        if (m_in_rst) begin
            chk({tag, ".rst_time"}, 64'(t), 64'd0);
            chk({tag, ".rst_sat"},  64'(s), 64'd0);
        end
        if (v === 1'b1) begin
            qsz = (i == 0) ? exp_q0.size() : exp_q1.size();
            chk({tag, ".result_expected"}, 64'(qsz), 64'd1);
            if (qsz > 0) begin
                head = (i == 0) ? exp_q0[0] : exp_q1[0];
                chk({tag, ".meas_time"}, 64'(t), 64'(head[31:0]));
                chk({tag, ".meas_sat"},  64'(s), 64'(head[32]));
                if (meas_ready === 1'b1) begin
                    if (i == 0) void'(exp_q0.pop_front());
                    else        void'(exp_q1.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        check_inst(0, a_valid, a_time, a_sat, a_timeout, a_overrun);
        check_inst(1, b_valid, {{(32 - B_W){1'b0}}, b_time}, b_sat, b_timeout, b_overrun);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        pulse_in = 1'b0;
        tick(n);
        rst = 1'b1;
        tick(2);
    endtask

    // Rising edge now, high for hi cycles, next edge period cycles later.
    task automatic pulse_edge(input int hi, input int period);
        pulse_in = 1'b1;
        tick(hi);
        pulse_in = 1'b0;
        tick(period - hi);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hi;
        int per;
        rst        = 1'b0;
        pulse_in   = 1'b0;
        meas_ready = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(3);

        // Regular train, every 16 cycles, consumer always ready.
        meas_ready = 1'b1;
        repeat (6) pulse_edge(4, 16);

        // Held result with intervals 16 then 20: second one dropped.
        do_reset(2);
        meas_ready = 1'b0;
        pulse_edge(3, 16);
        pulse_edge(3, 20);
        pulse_edge(3, 6);
        tick(5);
        meas_ready = 1'b1;
        tick(3);

        // Edges 20 apart: saturates the 4-bit instance.
        do_reset(2);
        repeat (3) pulse_edge(5, 20);
        pulse_edge(5, 15);
        pulse_edge(5, 16);

        // Single edge then silence past the timeout.
        do_reset(2);
        pulse_edge(2, 60);
        pulse_edge(2, 10);
        pulse_edge(2, 10);
        pulse_edge(2, 50);
        pulse_edge(2, 8);

        // Reset 8 cycles into an interval; edges 10 after release, then 12 later.
        do_reset(2);
        pulse_edge(2, 8);
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(10);
        pulse_edge(2, 12);
        pulse_edge(2, 5);

        // Minimum interval: input toggling every cycle.
        do_reset(2);
        repeat (12) pulse_edge(1, 2);
        tick(4);

        // Random trains with random back-pressure and occasional resets.
        do_reset(2);
        repeat (150) begin
            if ($urandom_range(0, 40) == 0) do_reset($urandom_range(1, 3));
            hi  = $urandom_range(1, 6);
            per = hi + $urandom_range(1, 70);
            for (int c = 0; c < per; c++) begin
                pulse_in   = (c < hi);
                meas_ready = ($urandom_range(0, 3) != 0);
                tick(1);
            end
        end

        // Drain: everything produced must have been consumed.
        pulse_in   = 1'b0;
        meas_ready = 1'b1;
        tick(6);
        chk("a.drain", 64'(exp_q0.size()), 64'd0);
        chk("b.drain", 64'(exp_q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_interval_meter.md
PULSE_INTERVAL_METER -- requirements
Module: pulse_interval_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the interval counter and result.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 0, idle-interval limit in clk cycles; 0 disables timeout.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port pulse_in  input  1  pulse train from pulse_generator (pulse_out).
REQ-006 SHALL have port meas_time  output  CNT_W  measured interval between consecutive rising edges, in clk cycles.
REQ-007 SHALL have port meas_valid  output  1  meas_time holds an unconsumed result.
REQ-008 SHALL have port meas_ready  input  1  consumer accepts result when high with meas_valid.
REQ-009 SHALL have port meas_sat  output  1  qualifies meas_time: counter saturated during this interval.
REQ-010 SHALL have port timeout  output  1  one-cycle strobe, no edge within TIMEOUT_CYC.
REQ-011 SHALL have port overrun  output  1  sticky, a result was dropped.

Function
REQ-012 SHALL detect a rising edge as sampled pulse_in high while previous sample low; a held-high input yields one edge.
REQ-013 SHALL implement FSM states IDLE (await first edge) and COUNT (timing interval).
REQ-014 SHALL transition IDLE->COUNT on first edge, producing no result.
REQ-015 SHALL, in COUNT, report interval = difference of clock-cycle indices of the two edges (edges at cycles 10 and 26 -> 16), then remain in COUNT with the second edge as new start.
REQ-016 SHALL assert meas_valid in the cycle after the closing edge is detected.
REQ-017 SHALL hold meas_time, meas_sat and meas_valid stable until the cycle after meas_valid && meas_ready.
REQ-018 SHALL, on a new result while a held result is not accepted, drop the new result and set overrun.
REQ-019 SHALL, when meas_ready accepts in the same cycle a new result is produced, load the new result with meas_valid staying high and no overrun.
REQ-020 SHALL saturate the counter at 2^CNT_W-1 (no wrap) and report meas_sat=1 with that value.
REQ-021 SHALL, when TIMEOUT_CYC!=0 and the running interval reaches TIMEOUT_CYC without an edge, pulse timeout for one cycle and return to IDLE; an edge in that same cycle wins (result produced, no timeout).
REQ-022 SHALL treat minimum interval of 2 cycles (pulse_in toggling every cycle) correctly.

Reset
REQ-023 SHALL, while rst=0 at a clk edge, force: FSM=IDLE, counter=0, edge-history=0, meas_time=0, meas_valid=0, meas_sat=0, timeout=0, overrun=0.
REQ-024 SHALL discard any in-progress interval on reset mid-measurement; first edge after reset only starts timing.
REQ-025 SHALL clear overrun only by reset.

Configuration
REQ-026 SHALL, with macro PULSE_INTERVAL_METER_SYNC_EN defined, pass pulse_in through a two-flop synchronizer before edge detection, adding 2 cycles latency to meas_valid, intervals unchanged.
REQ-027 SHALL, without PULSE_INTERVAL_METER_SYNC_EN, sample pulse_in directly (same-clock source).

Structure
REQ-028 SHALL place the FSM state enum and default CNT_W constant in shared package pulse_pkg, also usable by pulse_generator.
REQ-029 SHALL implement edge detection (plus optional synchronizer) as sub-module pulse_edge_detect; counter, FSM and result register in the top.

Verification
REQ-030 SHALL cover: pulse_generator-style train, edges every 16 cycles, meas_ready=1 -> first edge no result, each later edge gives meas_time=16, meas_sat=0.
REQ-031 SHALL cover: meas_ready=0 across two results (intervals 16, 20) -> meas_time stays 16, overrun=1 after second edge; ready high then -> 16 consumed, meas_valid drops.
REQ-032 SHALL cover: CNT_W=4, edges 20 cycles apart -> meas_time=15, meas_sat=1.
REQ-033 SHALL cover: TIMEOUT_CYC=50, one edge then silence -> timeout strobe exactly 50 cycles after edge, next edge yields no result.
REQ-034 SHALL cover: rst=0 asserted mid-interval 8 cycles after an edge, edge 10 cycles after release, then edge 12 later -> only 12 reported, all outputs 0 during reset.
REQ-035 SHALL cover: SYNC_EN build, same train as REQ-030 -> meas_time=16, meas_valid 2 cycles later than non-sync build.
